dec2to4_strobe: RTL and testbench

Sequenced 2-to-4 decoder: the receive-side counterpart of the 4:2 encoder in the combinational library. It accepts 2-bit codes on a valid/ready handshake, buffers up to two of them, and drives each code as a one-hot strobe for a fixed number of cycles. Each strobe is followed by an optional idle gap, so downstream select lines see clean, non-overlapping pulses. It sits between an encoder-fed code stream and the one-hot select lines it ultimately controls.

---
 rtl/dec2to4_strobe.sv | 142 ++++++++++++++
 tb/tb_dec2to4_strobe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec2to4_strobe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dec2to4_strobe                                                  |
// | Brief    : 2-entry buffered 2-to-4 decoder emitting timed one-hot strobes. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dec2to4_strobe #(
   parameter int HOLD = 4,
   parameter int GAP  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] in_code,
   output logic       in_ready,
   output logic [3:0] dec_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] decode_cnt
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_hold   = 2'd1;
   localparam logic [1:0] c_st_gap    = 2'd2;
   localparam logic [3:0] c_hold_load = 4'(HOLD - 1);
   localparam logic [3:0] c_gap_load  = 4'(GAP - 1);

   logic [1:0] r_state;
   logic [3:0] r_hold_cnt;
   logic [3:0] r_gap_cnt;
   logic [3:0] r_dec;
   logic [7:0] r_decode_cnt;
   logic [1:0] r_mem [0:1];
   logic [1:0] r_count;
   logic       r_rptr;
   logic       r_wptr;

   logic [1:0] w_state_nxt;
   logic [3:0] w_hold_nxt;
   logic [3:0] w_gap_nxt;
   logic [3:0] w_dec_nxt;
   logic [7:0] w_decode_cnt_nxt;
   logic [1:0] w_count_nxt;
   logic       w_push;
   logic       w_pop;

   // State register: FIFO storage, pointers and FSM state share one reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_st_idle;
         r_hold_cnt   <= 4'd0;
         r_gap_cnt    <= 4'd0;
         r_dec        <= 4'd0;
         r_decode_cnt <= 8'd0;
         r_mem[0]     <= 2'd0;
         r_mem[1]     <= 2'd0;
         r_count      <= 2'd0;
         r_rptr       <= 1'b0;
         r_wptr       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_dec        <= w_dec_nxt;
         r_decode_cnt <= w_decode_cnt_nxt;
         r_count      <= w_count_nxt;
         if (w_push) begin
            r_mem[r_wptr] <= in_code;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
      end
   end

   // Next-state logic; a pop is only possible from IDLE, which forces the
   // single idle cycle between strobes even when GAP is zero.
   always_comb begin
      w_state_nxt      = r_state;
      w_hold_nxt       = r_hold_cnt;
      w_gap_nxt        = r_gap_cnt;
      w_dec_nxt        = r_dec;
      w_decode_cnt_nxt = r_decode_cnt;
      w_push           = in_valid && in_ready;
      w_pop            = 1'b0;

      case (r_state)
         c_st_idle: begin
            w_dec_nxt = 4'd0;
            if (r_count != 2'd0) begin
               w_pop       = 1'b1;
               w_dec_nxt   = 4'b0001 << r_mem[r_rptr];
               w_hold_nxt  = c_hold_load;
               w_state_nxt = c_st_hold;
            end
         end
         c_st_hold: begin
            if (r_hold_cnt == 4'd0) begin
               w_dec_nxt        = 4'd0;
               w_decode_cnt_nxt = r_decode_cnt + 8'd1;
               if (GAP == 0) begin
                  w_state_nxt = c_st_idle;
               end else begin
                  w_gap_nxt   = c_gap_load;
                  w_state_nxt = c_st_gap;
               end
            end else begin
               w_hold_nxt = r_hold_cnt - 4'd1;
            end
         end
         c_st_gap: begin
            w_dec_nxt = 4'd0;
            if (r_gap_cnt == 4'd0) begin
               w_state_nxt = c_st_idle;
            end else begin
               w_gap_nxt = r_gap_cnt - 4'd1;
            end
         end
         default: begin
            w_dec_nxt   = 4'd0;
            w_state_nxt = c_st_idle;
         end
      endcase

      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      in_ready   = (r_count < 2'd2);
      busy       = (r_state != c_st_idle) || (r_count != 2'd0);
      done       = (r_state == c_st_hold) && (r_hold_cnt == 4'd0);
      dec_out    = r_dec;
      decode_cnt = r_decode_cnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_dec2to4_strobe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dec2to4_strobe                                               |
// | Brief    : Bench for dec2to4_strobe at HOLD=4/GAP=1 and HOLD=1/GAP=0.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dec2to4_strobe;

   localparam int H0 = 4;
   localparam int G0 = 1;
   localparam int H1 = 1;
   localparam int G1 = 0;

   logic       clk;
   logic       rst;
   logic       in_valid_s [2];
   logic [1:0] in_code_s  [2];
   logic       in_ready_s [2];
   logic [3:0] dec_s      [2];
   logic       busy_s     [2];
   logic       done_s     [2];
   logic [7:0] cnt_s      [2];

   int total;
   int bad;

   // Reference model: queued codes plus position inside the current strobe period.
   int m_n     [2];
   int m_buf   [2][2];
   bit m_act   [2];
   int m_pos   [2];
   int m_cur   [2];
   int m_cnt   [2];
   int m_dtot  [2];
   bit m_acc   [2];

   dec2to4_strobe #(.HOLD(H0), .GAP(G0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_code(in_code_s[0]),
      .in_ready(in_ready_s[0]), .dec_out(dec_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .decode_cnt(cnt_s[0]));

   dec2to4_strobe #(.HOLD(H1), .GAP(G1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_code(in_code_s[1]),
      .in_ready(in_ready_s[1]), .dec_out(dec_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .decode_cnt(cnt_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int hold_of(int i);
      return (i == 0) ? H0 : H1;
   endfunction

   function automatic int gap_of(int i);
      return (i == 0) ? G0 : G1;
   endfunction

   function automatic logic [3:0] exp_dec(int i);
      if (m_act[i] && m_pos[i] < hold_of(i)) return 4'(1 << m_cur[i]);
      return 4'b0000;
   endfunction

   function automatic logic exp_done(int i);
      return m_act[i] && (m_pos[i] == hold_of(i) - 1);
   endfunction

   function automatic logic exp_busy(int i);
      return m_act[i] || (m_n[i] > 0);
   endfunction

   function automatic logic exp_ready(int i);
      return m_n[i] < 2;
   endfunction

   task automatic model_clear(int i);
      m_n[i]   = 0;
      m_act[i] = 0;
      m_pos[i] = 0;
      m_cur[i] = 0;
      m_cnt[i] = 0;
      m_acc[i] = 0;
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            model_clear(i);
            continue;
         end
         m_acc[i] = in_valid_s[i] && (m_n[i] < 2);
         if (m_act[i]) begin
            m_pos[i]++;
            if (m_pos[i] == hold_of(i)) begin
               m_cnt[i] = (m_cnt[i] + 1) % 256;
               m_dtot[i]++;
            end
            if (m_pos[i] == hold_of(i) + gap_of(i)) m_act[i] = 0;
         end else if (m_n[i] > 0) begin
            m_cur[i]    = m_buf[i][0];
            m_buf[i][0] = m_buf[i][1];
            m_n[i]--;
            m_act[i] = 1;
            m_pos[i] = 0;
         end
         if (m_acc[i]) begin
            m_buf[i][m_n[i]] = int'(in_code_s[i]);
            m_n[i]++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         total++; if (dec_s[i] !== 4'd0) begin bad++; $display("FAIL reset_dec dut%0d got=%b want=0000", i, dec_s[i]); end
         total++; if (in_ready_s[i] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d got=%b want=1", i, in_ready_s[i]); end
         total++; if (busy_s[i] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b want=0", i, busy_s[i]); end
         total++; if (done_s[i] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d got=%b want=0", i, done_s[i]); end
         total++; if (cnt_s[i] !== 8'd0) begin bad++; $display("FAIL reset_cnt dut%0d got=%0d want=0", i, cnt_s[i]); end
      end
   endtask

   task automatic test_single();
      in_valid_s[0] = 1'b1;
      in_code_s[0]  = 2'b10;
      tick();
      in_valid_s[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         total++; if (dec_s[0] !== exp_dec(0)) begin bad++; $display("FAIL single_dec cyc%0d got=%b want=%b", c, dec_s[0], exp_dec(0)); end
         total++; if (done_s[0] !== exp_done(0)) begin bad++; $display("FAIL single_done cyc%0d got=%b want=%b", c, done_s[0], exp_done(0)); end
         total++; if (busy_s[0] !== exp_busy(0)) begin bad++; $display("FAIL single_busy cyc%0d got=%b want=%b", c, busy_s[0], exp_busy(0)); end
         tick();
      end
      total++; if (cnt_s[0] !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", cnt_s[0]); end
      total++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy_s[0]); end
   endtask

   task automatic test_sweep();
      int k = 0;
      for (int c = 0; c < 60; c++) begin
         in_valid_s[0] = (k < 4);
         in_code_s[0]  = 2'(k);
         tick();
         if (m_acc[0]) k++;
         total++; if (dec_s[0] !== exp_dec(0)) begin bad++; $display("FAIL sweep_dec cyc%0d got=%b want=%b", c, dec_s[0], exp_dec(0)); end
         if ($countones(dec_s[0]) > 1) begin bad++; $display("FAIL sweep_onehot cyc%0d got=%b want<=1 bit", c, dec_s[0]); end
      end
      in_valid_s[0] = 1'b0;
      total++; if (k != 4) begin bad++; $display("FAIL sweep_accept got=%0d want=4", k); end
      total++; if (cnt_s[0] !== 8'(m_cnt[0])) begin bad++; $display("FAIL sweep_cnt got=%0d want=%0d", cnt_s[0], m_cnt[0]); end
   endtask

   task automatic test_reset_mid();
      in_valid_s[0] = 1'b1;
      in_code_s[0]  = 2'b11;
      tick();
      in_valid_s[0] = 1'b0;
      tick(); tick(); tick();
      total++; if (dec_s[0] !== 4'b1000) begin bad++; $display("FAIL midrst_pre got=%b want=1000", dec_s[0]); end
      #2 rst = 1'b1;
      #1;
      total++; if (dec_s[0] !== 4'd0) begin bad++; $display("FAIL midrst_dec got=%b want=0000", dec_s[0]); end
      total++; if (cnt_s[0] !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt_s[0]); end
      model_clear(0);
      model_clear(1);
      tick();
      rst = 1'b0;
      #1;
      total++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready_s[0]); end
      total++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy_s[0]); end
   endtask

   task automatic test_backpressure();
      int k = 0;
      int seen [$];
      logic [3:0] prev = 4'd0;
      for (int c = 0; c < 60; c++) begin
         in_valid_s[0] = (k < 4);
         in_code_s[0]  = 2'(k);
         tick();
         if (m_acc[0]) k++;
         total++; if (in_ready_s[0] !== exp_ready(0)) begin bad++; $display("FAIL bp_ready cyc%0d got=%b want=%b", c, in_ready_s[0], exp_ready(0)); end
         total++; if (dec_s[0] !== exp_dec(0)) begin bad++; $display("FAIL bp_dec cyc%0d got=%b want=%b", c, dec_s[0], exp_dec(0)); end
         if (dec_s[0] != 4'd0 && prev == 4'd0) begin
            for (int b = 0; b < 4; b++) if (dec_s[0][b]) seen.push_back(b);
         end
         prev = dec_s[0];
      end
      in_valid_s[0] = 1'b0;
      total++;
      if (seen.size() != 4) begin
         bad++; $display("FAIL bp_strobes got=%0d want=4", seen.size());
      end else begin
         for (int b = 0; b < 4; b++)
            if (seen[b] != b) begin bad++; $display("FAIL bp_order idx%0d got=%0d want=%0d", b, seen[b], b); end
      end
   endtask

   task automatic test_gap0();
      logic [3:0] want [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      in_valid_s[1] = 1'b1;
      in_code_s[1]  = 2'b01;
      tick();
      in_code_s[1]  = 2'b11;
      tick();
      in_valid_s[1] = 1'b0;
      // First negedge after the second push is already the 0010 cycle.
      for (int c = 1; c < 6; c++) begin
         total++; if (dec_s[1] !== want[c]) begin bad++; $display("FAIL gap0_dec cyc%0d got=%b want=%b", c, dec_s[1], want[c]); end
         total++; if (done_s[1] !== exp_done(1)) begin bad++; $display("FAIL gap0_done cyc%0d got=%b want=%b", c, done_s[1], exp_done(1)); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            in_valid_s[i] = 1'($urandom_range(0, 1));
            in_code_s[i]  = 2'($urandom);
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            total++; if (dec_s[i] !== exp_dec(i)) begin bad++; $display("FAIL rnd_dec dut%0d cyc%0d got=%b want=%b", i, c, dec_s[i], exp_dec(i)); end
            total++; if (done_s[i] !== exp_done(i)) begin bad++; $display("FAIL rnd_done dut%0d cyc%0d got=%b want=%b", i, c, done_s[i], exp_done(i)); end
            total++; if (busy_s[i] !== exp_busy(i)) begin bad++; $display("FAIL rnd_busy dut%0d cyc%0d got=%b want=%b", i, c, busy_s[i], exp_busy(i)); end
            total++; if (in_ready_s[i] !== exp_ready(i)) begin bad++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b want=%b", i, c, in_ready_s[i], exp_ready(i)); end
            total++; if (cnt_s[i] !== 8'(m_cnt[i])) begin bad++; $display("FAIL rnd_cnt dut%0d cyc%0d got=%0d want=%0d", i, c, cnt_s[i], m_cnt[i]); end
         end
      end
      in_valid_s[0] = 1'b0;
      in_valid_s[1] = 1'b0;
   endtask

   task automatic test_wrap();
      bit reached = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_dtot[1] = 0;
      in_valid_s[1] = 1'b1;
      for (int c = 0; c < 1200 && !reached; c++) begin
         in_code_s[1] = 2'($urandom);
         tick();
         if (m_dtot[1] == 255) begin
            total++; if (cnt_s[1] !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", cnt_s[1]); end
         end
         if (m_dtot[1] == 256) reached = 1;
      end
      in_valid_s[1] = 1'b0;
      total++; if (!reached) begin bad++; $display("FAIL wrap_timeout got=%0d want=256 strobes", m_dtot[1]); end
      total++; if (cnt_s[1] !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0d want=0", cnt_s[1]); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid_s[i] = 1'b0;
         in_code_s[i]  = 2'b00;
         m_dtot[i]     = 0;
         model_clear(i);
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
      test_reset();
      test_single();
      test_sweep();
      test_reset_mid();
      test_backpressure();
      test_gap0();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
